// File: rtl/instr_fetch.sv
// LEGv8 fetch stage: PC register, one-word ready/ack fetch, registered instruction and next-PC selection.
// Build option: define FETCH_BR_EN to honour register-indirect branches (BR/br_reg).
//
// state | meaning
// FETCH | request outstanding at pc, waiting for imem_ack
// VALID | instr/instr_pc held for decode until id_ready
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        id_ready,
    input  logic        BrTaken,
    input  logic        UncondBr,
    input  logic        BR,
    input  logic [63:0] br_reg,
    output logic [63:0] pc_plus4
);

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic [31:0] instr_nxt;
    logic [63:0] instr_pc_nxt;
    logic        instr_valid_nxt;
    logic        req_fsm;
    logic [63:0] br_off;
    logic [63:0] target_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC_ALIGNED;
            instr       <= 32'h0;
            instr_pc    <= 64'h0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
        end
    end

    // Offsets come from the registered instruction, so there is no loop through decode.
    always_comb begin
        if (UncondBr) begin
            br_off = {{36{instr[25]}}, instr[25:0], 2'b00};
        end else begin
            br_off = {{43{instr[23]}}, instr[23:5], 2'b00};
        end
    end

`ifdef FETCH_BR_EN
    logic [1:0] unused_br_lsb;
    assign unused_br_lsb = br_reg[1:0];

    always_comb begin
        if (BR) begin
            target_pc = {br_reg[63:2], 2'b00};
        end else if (BrTaken) begin
            target_pc = instr_pc + br_off;
        end else begin
            target_pc = instr_pc + 64'd4;
        end
    end
`else
    logic unused_br;
    assign unused_br = ^{BR, br_reg};

    always_comb begin
        if (BrTaken) begin
            target_pc = instr_pc + br_off;
        end else begin
            target_pc = instr_pc + 64'd4;
        end
    end
`endif

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        req_fsm         = 1'b0;
        case (state)
            FETCH: begin
                req_fsm = 1'b1;
                if (imem_ack) begin
                    instr_nxt       = imem_rdata;
                    instr_pc_nxt    = pc;
                    instr_valid_nxt = 1'b1;
                    state_nxt       = VALID;
                end
            end
            VALID: begin
                // Branch inputs are only looked at here, so garbage while stalled is harmless.
                if (id_ready) begin
                    pc_nxt          = target_pc;
                    instr_valid_nxt = 1'b0;
                    state_nxt       = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Gating with rst_n drops the request immediately when reset asserts mid-fetch.
    assign imem_req  = req_fsm & rst_n;
    assign imem_addr = pc;
    assign pc_plus4  = instr_pc + 64'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, wait states, branch redirects, stalls, reset and wrap.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        id_ready;
    logic        BrTaken;
    logic        UncondBr;
    logic        BR;
    logic [63:0] br_reg;
    logic [63:0] pc_plus4;

    int          n_checks;
    int          n_fail;
    int          ack_delay;
    int          wait_cnt;
    logic        ack_force;
    logic [31:0] rdata_drv;

`ifdef FETCH_BR_EN
    localparam logic [63:0] BR_EXP = 64'h4000;
`else
    localparam logic [63:0] BR_EXP = 64'h220;
`endif

    instr_fetch #(.RESET_PC(64'h100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .id_ready    (id_ready),
        .BrTaken     (BrTaken),
        .UncondBr    (UncondBr),
        .BR          (BR),
        .br_reg      (br_reg),
        .pc_plus4    (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after ack_delay request cycles; ack_force injects stray acks.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (imem_req && !imem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    assign imem_ack   = (imem_req && (wait_cnt >= ack_delay)) || ack_force;
    assign imem_rdata = rdata_drv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Entered in FETCH; leaves in VALID with the fetched word checked.
    task automatic do_fetch(input logic [63:0] exp_addr, input logic [31:0] word, input int delay);
        ack_delay = delay;
        rdata_drv = word;
        for (int i = 0; i < delay; i++) begin
            chk("wait_req", {63'd0, imem_req}, 64'd1);
            chk("wait_addr", imem_addr, exp_addr);
            chk("wait_valid", {63'd0, instr_valid}, 64'd0);
            step();
        end
        chk("fetch_req", {63'd0, imem_req}, 64'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        chk("fetch_valid", {63'd0, instr_valid}, 64'd0);
        step();
        chk("valid", {63'd0, instr_valid}, 64'd1);
        chk("instr", {32'd0, instr}, {32'd0, word});
        chk("instr_pc", instr_pc, exp_addr);
        chk("pc_plus4", pc_plus4, exp_addr + 64'd4);
        chk("valid_req", {63'd0, imem_req}, 64'd0);
    endtask

    task automatic consume(input logic br, input logic taken, input logic unc, input logic [63:0] breg);
        id_ready = 1'b1;
        BR       = br;
        BrTaken  = taken;
        UncondBr = unc;
        br_reg   = breg;
        step();
        id_ready = 1'b0;
        BR       = 1'($urandom);
        BrTaken  = 1'($urandom);
        UncondBr = 1'($urandom);
        br_reg   = {$urandom, $urandom};
        chk("consume_valid", {63'd0, instr_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic [31:0] hold_word;
        n_checks  = 0;
        n_fail    = 0;
        ack_delay = 0;
        ack_force = 1'b0;
        rdata_drv = 32'h0;
        id_ready  = 1'b0;
        BR        = 1'b0;
        BrTaken   = 1'b0;
        UncondBr  = 1'b0;
        br_reg    = 64'h0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        step();
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_instr_pc", instr_pc, 64'd0);
        step();
        rst_n = 1'b1;
        #1;

        do_fetch(64'h100, 32'hAAAA_0001, 0);
        consume(1'b0, 1'b0, 1'b0, 64'h0);
        do_fetch(64'h104, 32'hAAAA_0002, 0);
        consume(1'b0, 1'b0, 1'b0, 64'h0);
        do_fetch(64'h108, 32'h0000_003E, 0);       // B +0x3E words -> 0x200
        consume(1'b0, 1'b1, 1'b1, 64'h0);

        do_fetch(64'h200, 32'h03FF_FFFE, 0);       // B -2 words -> 0x1F8
        consume(1'b0, 1'b1, 1'b1, 64'h0);
        do_fetch(64'h1F8, 32'h0000_0040, 0);       // CBZ +2 words -> 0x200
        consume(1'b0, 1'b1, 1'b0, 64'h0);
        do_fetch(64'h200, 32'h0000_0080, 0);       // CBZ +4 words -> 0x210
        consume(1'b0, 1'b1, 1'b0, 64'h0);

        do_fetch(64'h210, 32'h0000_0080, 0);
        consume(1'b1, 1'b1, 1'b0, 64'h4003);

        d         = 64'h300 - BR_EXP;
        hold_word = {6'd0, d[27:2]};
        do_fetch(BR_EXP, hold_word, 0);
        ack_force = 1'b1;
        rdata_drv = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            BrTaken  = 1'($urandom);
            BR       = 1'($urandom);
            UncondBr = 1'($urandom);
            br_reg   = {$urandom, $urandom};
            step();
            chk("hold_valid", {63'd0, instr_valid}, 64'd1);
            chk("hold_instr", {32'd0, instr}, {32'd0, hold_word});
            chk("hold_instr_pc", instr_pc, BR_EXP);
            chk("hold_req", {63'd0, imem_req}, 64'd0);
        end
        ack_force = 1'b0;
        consume(1'b0, 1'b1, 1'b1, 64'h0);

        ack_delay = 5;
        chk("mid_req", {63'd0, imem_req}, 64'd1);
        chk("mid_addr", imem_addr, 64'h300);
        step();
        chk("mid_addr2", imem_addr, 64'h300);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {63'd0, imem_req}, 64'd0);
        chk("mid_rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("mid_rst_instr_pc", instr_pc, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        do_fetch(64'h100, 32'h03FF_FFBF, 0);       // B -0x41 words -> 0xFFFF_FFFF_FFFF_FFFC
        consume(1'b0, 1'b1, 1'b1, 64'h0);
        do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h1111_2222, 0);
        consume(1'b0, 1'b0, 1'b0, 64'h0);
        do_fetch(64'h0, 32'h3333_4444, 3);
        consume(1'b0, 1'b0, 1'b0, 64'h0);
        chk("final_addr", imem_addr, 64'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
